// File: rtl/fetch_controller.sv
// Fetch control producer: arbitrates halt, return-from-interrupt, branch redirect,
// interrupt dispatch and hazard stall into one set of fetch-unit commands per cycle.
//
// state   | meaning
// --------+-----------------------------------------------
// RUN     | normal execution, interrupts may be dispatched
// HANDLER | inside a (non-nested) interrupt handler
// HALTED  | halt executed, terminal until reset
module fetch_controller #(
  parameter int PC_SIZE     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [14:0]        irq_i,
  input  logic [14:0]        int_mask_i,
  input  logic               br_taken_i,
  input  logic [PC_SIZE-1:0] br_target_i,
  input  logic               hazard_stall_i,
  input  logic               halt_req_i,
  input  logic               rti_req_i,
  output logic               halt_o,
  output logic               interrupt_o,
  output logic [3:0]         int_code_o,
  output logic               pc_override_o,
  output logic [PC_SIZE-1:0] target_o,
  output logic               stall_o,
  output logic               flush_o,
  output logic               in_handler_o,
  output logic [3:0]         active_code_o,
  output logic               spurious_rti_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [SYNC_STAGES-1:0][14:0]     sync_q;
  logic [14:0]                      prev_q;
  logic [14:0]                      pending_q, pending_d;
  logic [3:0]                       active_q, active_d;
  logic                             spurious_q, spurious_d;

  logic [14:0]                      irq_rise;
  logic [14:0]                      eligible;
  logic [14:0]                      win_oh;
  logic [3:0]                       win_code;
  logic [14:0]                      clr;

  logic                             halt_c, interrupt_c, pc_override_c, stall_c, flush_c;
  logic [3:0]                       int_code_c;
  logic [PC_SIZE-1:0]               target_c;

  assign irq_rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign eligible = pending_q & int_mask_i;

  // Descending scan so the lowest-numbered eligible code is the last assignment.
  always_comb begin
    win_oh   = '0;
    win_code = '0;
    for (int i = 14; i >= 0; i--) begin
      if (eligible[i]) begin
        win_oh   = 15'(1) << i;
        win_code = 4'(i + 1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    spurious_d    = spurious_q;
    clr           = '0;
    halt_c        = 1'b0;
    interrupt_c   = 1'b0;
    int_code_c    = '0;
    pc_override_c = 1'b0;
    target_c      = '0;
    stall_c       = 1'b0;
    flush_c       = 1'b0;

    case (state_q)
      HALTED: begin
        halt_c = 1'b1;
      end
      RUN, HANDLER: begin
        if (halt_req_i) begin
          halt_c  = 1'b1;
          flush_c = 1'b1;
          state_d = HALTED;
        end else if (rti_req_i && (state_q == HANDLER)) begin
          interrupt_c = 1'b1;
          int_code_c  = 4'd0;
          flush_c     = 1'b1;
          state_d     = RUN;
          active_d    = 4'd0;
        end else begin
          // A return outside any handler is recorded but otherwise ignored.
          if (rti_req_i) begin
            spurious_d = 1'b1;
          end
          if (br_taken_i) begin
            pc_override_c = 1'b1;
            target_c      = br_target_i;
            flush_c       = 1'b1;
          end else if ((state_q == RUN) && !hazard_stall_i && !rti_req_i && (|eligible)) begin
            interrupt_c = 1'b1;
            int_code_c  = win_code;
            flush_c     = 1'b1;
            clr         = win_oh;
            state_d     = HANDLER;
            active_d    = win_code;
          end else begin
            stall_c = hazard_stall_i;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // New edges are OR-ed in after the dispatch clear so a same-cycle edge survives.
  assign pending_d = (pending_q & ~clr) | irq_rise;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= RUN;
      sync_q     <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      active_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q     <= sync_q[SYNC_STAGES-1];
      pending_q  <= pending_d;
      active_q   <= active_d;
      spurious_q <= spurious_d;
    end
  end

  assign halt_o         = n_rst & halt_c;
  assign interrupt_o    = n_rst & interrupt_c;
  assign int_code_o     = n_rst ? int_code_c : 4'd0;
  assign pc_override_o  = n_rst & pc_override_c;
  assign target_o       = n_rst ? target_c : '0;
  assign stall_o        = n_rst & stall_c;
  assign flush_o        = n_rst & flush_c;
  assign in_handler_o   = (state_q == HANDLER);
  assign active_code_o  = active_q;
  assign spurious_rti_o = spurious_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: expected output vectors are queued as each
// step is driven and popped for comparison once the combinational outputs settle.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [14:0] irq;
  logic [14:0] int_mask;
  logic        br_taken;
  logic [15:0] br_target;
  logic        hazard_stall;
  logic        halt_req;
  logic        rti_req;
  logic        halt;
  logic        interrupt;
  logic [3:0]  int_code;
  logic        pc_override;
  logic [15:0] target;
  logic        stall;
  logic        flush;
  logic        in_handler;
  logic [3:0]  active_code;
  logic        spurious_rti;

  always #5 clk = ~clk;

  fetch_controller #(.PC_SIZE(16), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .irq_i          (irq),
    .int_mask_i     (int_mask),
    .br_taken_i     (br_taken),
    .br_target_i    (br_target),
    .hazard_stall_i (hazard_stall),
    .halt_req_i     (halt_req),
    .rti_req_i      (rti_req),
    .halt_o         (halt),
    .interrupt_o    (interrupt),
    .int_code_o     (int_code),
    .pc_override_o  (pc_override),
    .target_o       (target),
    .stall_o        (stall),
    .flush_o        (flush),
    .in_handler_o   (in_handler),
    .active_code_o  (active_code),
    .spurious_rti_o (spurious_rti)
  );

  // {halt, interrupt, int_code, pc_override, target, stall, flush, in_handler, active_code, spurious}
  logic [30:0] obs;
  assign obs = {halt, interrupt, int_code, pc_override, target, stall, flush,
                in_handler, active_code, spurious_rti};

  typedef struct {
    string       tag;
    logic [30:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic sp       = 1'b0;

  function automatic logic [30:0] ev(logic h, logic in, logic [3:0] c, logic pco,
                                     logic [15:0] t, logic st, logic fl, logic inh,
                                     logic [3:0] act, logic spr);
    return {h, in, c, pco, t, st, fl, inh, act, spr};
  endfunction

  function automatic logic [30:0] idle(logic inh, logic [3:0] act);
    return ev(1'b0, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, inh, act, sp);
  endfunction

  function automatic logic [30:0] irqev(logic [3:0] c, logic inh, logic [3:0] act);
    return ev(1'b0, 1'b1, c, 1'b0, 16'h0, 1'b0, 1'b1, inh, act, sp);
  endfunction

  task automatic push(input string tag, input logic [30:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    #2;
    x = sb_q.pop_front();
    n_assert++;
    assert (obs === x.exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", x.tag, obs, x.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst        = 1'b0;
    irq          = '0;
    int_mask     = '1;
    br_taken     = 1'b0;
    br_target    = '0;
    hazard_stall = 1'b0;
    halt_req     = 1'b0;
    rti_req      = 1'b0;

    // reset and idle
    cyc(); push("reset", idle(1'b0, 4'd0)); check();
    cyc(); n_rst = 1'b1; push("idle", idle(1'b0, 4'd0)); check();
    cyc(); hazard_stall = 1'b1;
    push("stall_run", ev(1'b0, 1'b0, 4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, sp)); check();

    // codes 3 and 7 arrive together
    cyc(); hazard_stall = 1'b0; irq[2] = 1'b1; irq[6] = 1'b1;
    push("irq_sync0", idle(1'b0, 4'd0)); check();
    cyc(); push("irq_sync1", idle(1'b0, 4'd0)); check();
    cyc(); push("irq_sync2", idle(1'b0, 4'd0)); check();
    cyc(); push("dispatch3", irqev(4'd3, 1'b0, 4'd0)); check();
    cyc(); irq = '0; push("handler3", idle(1'b1, 4'd3)); check();
    cyc(); push("handler3_hold", idle(1'b1, 4'd3)); check();
    cyc(); rti_req = 1'b1; push("rti3", irqev(4'd0, 1'b1, 4'd3)); check();
    cyc(); rti_req = 1'b0; push("dispatch7", irqev(4'd7, 1'b0, 4'd0)); check();
    cyc(); push("handler7", idle(1'b1, 4'd7)); check();
    cyc(); rti_req = 1'b1; push("rti7", irqev(4'd0, 1'b1, 4'd7)); check();
    cyc(); rti_req = 1'b0; push("idle_after7", idle(1'b0, 4'd0)); check();

    // branch beats an eligible interrupt
    cyc(); irq[1] = 1'b1; push("br_sync0", idle(1'b0, 4'd0)); check();
    cyc(); push("br_sync1", idle(1'b0, 4'd0)); check();
    cyc(); push("br_sync2", idle(1'b0, 4'd0)); check();
    cyc(); br_taken = 1'b1; br_target = 16'h0123;
    push("br_over_irq", ev(1'b0, 1'b0, 4'd0, 1'b1, 16'h0123, 1'b0, 1'b1, 1'b0, 4'd0, sp)); check();
    cyc(); br_taken = 1'b0; br_target = 16'h0;
    push("dispatch2_after_br", irqev(4'd2, 1'b0, 4'd0)); check();
    cyc(); irq = '0; push("handler2", idle(1'b1, 4'd2)); check();
    cyc(); br_taken = 1'b1; br_target = 16'hBEEF;
    push("br_in_handler", ev(1'b0, 1'b0, 4'd0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 4'd2, sp)); check();
    cyc(); br_taken = 1'b0; br_target = 16'h0; rti_req = 1'b1;
    push("rti2", irqev(4'd0, 1'b1, 4'd2)); check();
    cyc(); rti_req = 1'b0; push("idle_after2", idle(1'b0, 4'd0)); check();
    cyc(); push("idle_after2b", idle(1'b0, 4'd0)); check();

    // hazard stall defers dispatch
    cyc(); irq[1] = 1'b1; push("st_sync0", idle(1'b0, 4'd0)); check();
    cyc(); push("st_sync1", idle(1'b0, 4'd0)); check();
    cyc(); push("st_sync2", idle(1'b0, 4'd0)); check();
    for (int k = 0; k < 2; k++) begin
      cyc(); hazard_stall = 1'b1;
      push("stall_defers_irq", ev(1'b0, 1'b0, 4'd0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, sp));
      check();
    end
    cyc(); hazard_stall = 1'b0; push("dispatch2_after_stall", irqev(4'd2, 1'b0, 4'd0)); check();
    cyc(); irq = '0; push("handler2b", idle(1'b1, 4'd2)); check();
    cyc(); rti_req = 1'b1; push("rti2b", irqev(4'd0, 1'b1, 4'd2)); check();
    cyc(); rti_req = 1'b0; push("idle_after2b_rti", idle(1'b0, 4'd0)); check();

    // masked code 4 stays pending until unmasked
    cyc(); int_mask[3] = 1'b0; irq[3] = 1'b1; push("mask_sync0", idle(1'b0, 4'd0)); check();
    cyc(); irq[3] = 1'b0; push("mask_sync1", idle(1'b0, 4'd0)); check();
    cyc(); push("mask_sync2", idle(1'b0, 4'd0)); check();
    cyc(); push("masked_no_dispatch", idle(1'b0, 4'd0)); check();
    cyc(); push("masked_no_dispatch2", idle(1'b0, 4'd0)); check();
    cyc(); int_mask = '1; push("unmask_dispatch4", irqev(4'd4, 1'b0, 4'd0)); check();
    cyc(); push("handler4", idle(1'b1, 4'd4)); check();
    cyc(); rti_req = 1'b1; push("rti4", irqev(4'd0, 1'b1, 4'd4)); check();
    cyc(); rti_req = 1'b0; push("idle_after4", idle(1'b0, 4'd0)); check();

    // spurious return, then halt beats branch
    cyc(); rti_req = 1'b1; push("spurious_rti_noevent", idle(1'b0, 4'd0)); check();
    cyc(); rti_req = 1'b0; sp = 1'b1; push("spurious_sticky", idle(1'b0, 4'd0)); check();
    cyc(); push("spurious_sticky2", idle(1'b0, 4'd0)); check();
    cyc(); halt_req = 1'b1; br_taken = 1'b1; br_target = 16'h0456;
    push("halt_over_br", ev(1'b1, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, sp)); check();
    cyc(); halt_req = 1'b0; br_taken = 1'b0; br_target = 16'h0;
    push("halted", ev(1'b1, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, sp)); check();
    for (int k = 0; k < 4; k++) begin
      cyc(); irq = 15'h7FFF; br_taken = 1'b1; br_target = 16'h0789; hazard_stall = 1'b1;
      push("halted_ignores", ev(1'b1, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, sp));
      check();
    end
    cyc(); irq = '0; br_taken = 1'b0; br_target = 16'h0; hazard_stall = 1'b0;
    push("halted_quiet", ev(1'b1, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, sp)); check();
    cyc(); n_rst = 1'b0;
    cyc(); n_rst = 1'b1; sp = 1'b0; push("reset_from_halt", idle(1'b0, 4'd0)); check();

    // reset while in a handler with code 5 still pending
    cyc(); irq[0] = 1'b1; irq[4] = 1'b1; push("rst_sync0", idle(1'b0, 4'd0)); check();
    cyc(); push("rst_sync1", idle(1'b0, 4'd0)); check();
    cyc(); push("rst_sync2", idle(1'b0, 4'd0)); check();
    cyc(); push("dispatch1", irqev(4'd1, 1'b0, 4'd0)); check();
    cyc(); irq = '0; push("handler1", idle(1'b1, 4'd1)); check();
    cyc(); n_rst = 1'b0;
    cyc(); n_rst = 1'b1; push("reset_clears_handler", idle(1'b0, 4'd0)); check();
    for (int k = 0; k < 4; k++) begin
      cyc(); push("no_dispatch_after_reset", idle(1'b0, 4'd0)); check();
    end
    cyc(); irq[4] = 1'b1; push("new_sync0", idle(1'b0, 4'd0)); check();
    cyc(); push("new_sync1", idle(1'b0, 4'd0)); check();
    cyc(); push("new_sync2", idle(1'b0, 4'd0)); check();
    cyc(); push("dispatch5", irqev(4'd5, 1'b0, 4'd0)); check();
    cyc(); irq = '0; push("handler5", idle(1'b1, 4'd5)); check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
